mem_ctrl: RTL and testbench

Memory controller and arbiter that shares the single byte-wide synchronous RAM port between the instruction-fetch requester (IF) and the load/store requester (MEM). Sits between the IF and MEM pipeline stages and the RAM bus. Serialises multi-byte accesses into per-byte RAM cycles, assembles read data little-endian, and returns a one-cycle completion pulse to the granted requester.

---
 rtl/mem_ctrl_if.sv | 29 ++
 rtl/mem_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the IF/MEM requesters, the memory controller and the byte-wide RAM.
interface mem_ctrl_if #(parameter int ADDR_W = 32);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_cancel;
    logic              if_done;
    logic [31:0]       if_inst;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_a;
    logic              ram_wr;

    modport ctrl (
        input  if_req, if_addr, if_cancel, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
        output if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
    );

    modport master (
        output if_req, if_addr, if_cancel, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
        input  if_done, if_inst, mem_done, mem_rdata, ram_dout, ram_a, ram_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates the single byte-wide RAM port between instruction fetch and load/store,
// splitting each access into per-byte RAM cycles and assembling read data little-endian.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   rdy,
    mem_ctrl_if.ctrl bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner_mem;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_len;
    logic [2:0]        r_cnt;
    logic [31:0]       r_buf;
    logic              r_if_done;
    logic              r_mem_done;
    logic [31:0]       r_if_inst;
    logic [31:0]       r_mem_rdata;

    state_t            w_state_nx;
    logic              w_owner_nx;
    logic [ADDR_W-1:0] w_base_nx;
    logic [2:0]        w_len_nx;
    logic [2:0]        w_cnt_nx;
    logic [31:0]       w_buf_nx;
    logic              w_if_done_nx;
    logic              w_mem_done_nx;
    logic [31:0]       w_if_inst_nx;
    logic [31:0]       w_mem_rdata_nx;
    logic [1:0]        w_cap_idx;
    logic [31:0]       w_buf_cap;
    logic [ADDR_W-1:0] w_ram_a;
    logic [7:0]        w_ram_dout;
    logic              w_ram_wr;
    logic [ADDR_W-1:0] w_cnt_ext;

    function automatic logic [2:0] len_decode(input logic [1:0] code);
        case (code)
            2'b00:   len_decode = 3'd1;
            2'b01:   len_decode = 3'd2;
            default: len_decode = 3'd4;
        endcase
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner_mem <= 1'b0;
            r_base      <= {ADDR_W{1'b0}};
            r_len       <= 3'd0;
            r_cnt       <= 3'd0;
            r_buf       <= 32'd0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            r_state     <= w_state_nx;
            r_owner_mem <= w_owner_nx;
            r_base      <= w_base_nx;
            r_len       <= w_len_nx;
            r_cnt       <= w_cnt_nx;
            r_buf       <= w_buf_nx;
            r_if_done   <= w_if_done_nx;
            r_mem_done  <= w_mem_done_nx;
            r_if_inst   <= w_if_inst_nx;
            r_mem_rdata <= w_mem_rdata_nx;
        end
    end

    // Next-state, arbitration and read-data assembly
    always_comb begin
        w_state_nx     = r_state;
        w_owner_nx     = r_owner_mem;
        w_base_nx      = r_base;
        w_len_nx       = r_len;
        w_cnt_nx       = r_cnt;
        w_buf_nx       = r_buf;
        w_if_done_nx   = r_if_done;
        w_mem_done_nx  = r_mem_done;
        w_if_inst_nx   = r_if_inst;
        w_mem_rdata_nx = r_mem_rdata;
        // ram_din at this edge belongs to the address presented when cnt was one lower
        w_cap_idx      = r_cnt[1:0] - 2'd1;
        w_buf_cap      = r_buf;
        if (r_cnt != 3'd0) begin
            w_buf_cap[{w_cap_idx, 3'b000} +: 8] = bus.ram_din;
        end else begin
            w_buf_cap = r_buf;
        end

        if (rdy) begin
            w_if_done_nx  = 1'b0;
            w_mem_done_nx = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_if_done || r_mem_done) begin
                        w_state_nx = ST_IDLE;
                    end else if (bus.mem_req) begin
                        w_state_nx = bus.mem_we ? ST_WRITE : ST_READ;
                        w_owner_nx = 1'b1;
                        w_base_nx  = bus.mem_addr;
                        w_len_nx   = len_decode(bus.mem_len);
                        w_cnt_nx   = 3'd0;
                        w_buf_nx   = 32'd0;
                    end else if (bus.if_req) begin
                        w_state_nx = ST_READ;
                        w_owner_nx = 1'b0;
                        w_base_nx  = bus.if_addr;
                        w_len_nx   = 3'd4;
                        w_cnt_nx   = 3'd0;
                        w_buf_nx   = 32'd0;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (!r_owner_mem && bus.if_cancel) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = 3'd0;
                    end else if (r_cnt == r_len) begin
                        w_state_nx = ST_IDLE;
                        w_cnt_nx   = 3'd0;
                        w_buf_nx   = w_buf_cap;
                        if (r_owner_mem) begin
                            w_mem_done_nx  = 1'b1;
                            w_mem_rdata_nx = w_buf_cap;
                        end else begin
                            w_if_done_nx = 1'b1;
                            w_if_inst_nx = w_buf_cap;
                        end
                    end else begin
                        w_buf_nx = w_buf_cap;
                        w_cnt_nx = r_cnt + 3'd1;
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == (r_len - 3'd1)) begin
                        w_state_nx    = ST_IDLE;
                        w_cnt_nx      = 3'd0;
                        w_mem_done_nx = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt + 3'd1;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = 3'd0;
                end
            endcase
        end else begin
            w_state_nx = r_state;
        end
    end

    // RAM port decode from the registered state
    always_comb begin
        w_cnt_ext  = {{(ADDR_W-3){1'b0}}, r_cnt};
        w_ram_a    = {ADDR_W{1'b0}};
        w_ram_dout = 8'd0;
        w_ram_wr   = 1'b0;
        case (r_state)
            ST_READ: begin
                if (r_cnt < r_len) begin
                    w_ram_a = r_base + w_cnt_ext;
                end else begin
                    w_ram_a = {ADDR_W{1'b0}};
                end
            end
            ST_WRITE: begin
                w_ram_a    = r_base + w_cnt_ext;
                w_ram_dout = bus.mem_wdata[{r_cnt[1:0], 3'b000} +: 8];
                w_ram_wr   = rdy;
            end
            default: begin
                w_ram_a = {ADDR_W{1'b0}};
            end
        endcase
    end

    assign bus.ram_a     = w_ram_a;
    assign bus.ram_dout  = w_ram_dout;
    assign bus.ram_wr    = w_ram_wr;
    assign bus.if_done   = r_if_done;
    assign bus.if_inst   = r_if_inst;
    assign bus.mem_done  = r_mem_done;
    assign bus.mem_rdata = r_mem_rdata;
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed accesses against a small byte RAM model,
// completions and write strobes checked by independent negedge monitors.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    typedef struct {
        bit          is_mem;
        bit          chk_data;
        logic [31:0] data;
        int          edge_n;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    done_t      exp_q[$];
    wr_t        wr_q[$];
    done_t      mon_e;
    wr_t        mon_w;
    logic [7:0] ram [0:511];
    logic       prev_if_done = 1'b0;
    logic       prev_mem_done = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM: one-cycle read latency, preloaded while rst is high
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'h00;
            ram[9'h100] <= 8'h13; ram[9'h101] <= 8'h05; ram[9'h102] <= 8'h00; ram[9'h103] <= 8'h00;
            ram[9'h104] <= 8'h93; ram[9'h105] <= 8'h08; ram[9'h106] <= 8'h10; ram[9'h107] <= 8'h00;
            ram[9'h1FF] <= 8'hA1; ram[9'h000] <= 8'hB2; ram[9'h001] <= 8'hC3; ram[9'h002] <= 8'hD4;
            bus.ram_din <= 8'h00;
        end else begin
            if (bus.ram_wr) ram[bus.ram_a[8:0]] <= bus.ram_dout;
            bus.ram_din <= ram[bus.ram_a[8:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion and write-strobe monitors
    always @(negedge clk) begin
        if (bus.if_done || bus.mem_done) begin
            chk("both_done", {31'd0, bus.if_done & bus.mem_done}, 32'd0);
            chk("pulse_width", {30'd0, prev_if_done & bus.if_done, prev_mem_done & bus.mem_done}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done actual=if%0b_mem%0b required=none (cycle %0d)",
                         bus.if_done, bus.mem_done, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_owner", {31'd0, bus.mem_done}, {31'd0, mon_e.is_mem});
                chk("done_cycle", cyc, mon_e.edge_n);
                if (mon_e.chk_data) begin
                    chk("done_data", mon_e.is_mem ? bus.mem_rdata : bus.if_inst, mon_e.data);
                end
            end
        end
        if (bus.ram_wr) begin
            if (wr_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write actual=%h required=none (cycle %0d)", bus.ram_a, cyc);
            end else begin
                mon_w = wr_q.pop_front();
                chk("wr_addr", bus.ram_a, mon_w.addr);
                chk("wr_data", {24'd0, bus.ram_dout}, {24'd0, mon_w.data});
            end
        end
        prev_if_done  <= bus.if_done;
        prev_mem_done <= bus.mem_done;
    end

    task automatic push_done(input bit is_mem, input bit chk_data, input logic [31:0] data, input int edge_n);
        done_t e;
        e.is_mem = is_mem; e.chk_data = chk_data; e.data = data; e.edge_n = edge_n;
        exp_q.push_back(e);
    endtask

    task automatic push_word_writes(input logic [31:0] base, input logic [31:0] wd);
        wr_t w;
        for (int i = 0; i < 4; i++) begin
            w.addr = base + i;
            w.data = wd[8*i +: 8];
            wr_q.push_back(w);
        end
    endtask

    task automatic set_mem(input bit we, input logic [31:0] addr, input logic [1:0] len, input logic [31:0] wd);
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_len   = len;
        bus.mem_wdata = wd;
        bus.mem_req   = 1'b1;
    endtask

    task automatic wait_done(input bit is_mem);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (is_mem ? bus.mem_done : bus.if_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL done_timeout actual=no_done required=%s_done", is_mem ? "mem" : "if");
        end
        if (is_mem) bus.mem_req = 1'b0;
        else bus.if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst = 1'b1; rdy = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_cancel = 1'b0;
        bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = 32'd0;
        bus.mem_len = 2'b00; bus.mem_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_if_done", {31'd0, bus.if_done}, 32'd0);
        chk("rst_mem_done", {31'd0, bus.mem_done}, 32'd0);
        chk("rst_if_inst", bus.if_inst, 32'd0);
        chk("rst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("rst_ram_a", bus.ram_a, 32'd0);
        chk("rst_ram_dout", {24'd0, bus.ram_dout}, 32'd0);
        chk("rst_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word fetch at 0x100: addresses on consecutive cycles, done five edges after grant
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        push_done(1'b0, 1'b1, 32'h0000_0513, cyc + 6);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("fetch_addr", bus.ram_a, 32'h100 + i);
        end
        wait_done(1'b0);
        @(posedge clk); #1;

        // Store word then load half from its upper bytes
        push_word_writes(32'h20, 32'hDEAD_BEEF);
        push_done(1'b1, 1'b0, 32'd0, cyc + 5);
        set_mem(1'b1, 32'h20, 2'b10, 32'hDEAD_BEEF);
        wait_done(1'b1);
        @(posedge clk); #1;
        push_done(1'b1, 1'b1, 32'h0000_DEAD, cyc + 4);
        set_mem(1'b0, 32'h22, 2'b01, 32'd0);
        wait_done(1'b1);
        @(posedge clk); #1;

        // Simultaneous requests: MEM byte load wins, IF waits out the done cycle
        e = cyc;
        push_done(1'b1, 1'b1, 32'h0000_00BE, e + 3);
        push_done(1'b0, 1'b1, 32'h0010_0893, e + 10);
        set_mem(1'b0, 32'h21, 2'b00, 32'd0);
        bus.if_addr = 32'h104; bus.if_req = 1'b1;
        wait_done(1'b1);
        wait_done(1'b0);
        @(posedge clk); #1;

        // Cancel a fetch at cnt 2 while a MEM load is pending
        e = cyc;
        bus.if_addr = 32'h108; bus.if_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus.if_cancel = 1'b1; bus.if_req = 1'b0;
        set_mem(1'b0, 32'h20, 2'b10, 32'd0);
        push_done(1'b1, 1'b1, 32'hDEAD_BEEF, e + 10);
        @(posedge clk); #1;
        chk("cancel_idle_ram_a", bus.ram_a, 32'd0);
        bus.if_cancel = 1'b0;
        wait_done(1'b1);
        @(posedge clk); #1;

        // Store word with rdy low for three edges after the second byte is presented
        e = cyc;
        push_word_writes(32'h40, 32'h1122_3344);
        push_done(1'b1, 1'b0, 32'd0, e + 8);
        set_mem(1'b1, 32'h40, 2'b10, 32'h1122_3344);
        repeat (2) begin @(posedge clk); #1; end
        rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("frozen_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
        end
        rdy = 1'b1;
        wait_done(1'b1);
        @(posedge clk); #1;
        push_done(1'b1, 1'b1, 32'h1122_3344, cyc + 6);
        set_mem(1'b0, 32'h40, 2'b10, 32'd0);
        wait_done(1'b1);
        @(posedge clk); #1;

        // Word load across the top of the address space
        push_done(1'b1, 1'b1, 32'hD4C3_B2A1, cyc + 6);
        set_mem(1'b0, 32'hFFFF_FFFF, 2'b10, 32'd0);
        wait_done(1'b1);
        @(posedge clk); #1;

        // Reset in the middle of a fetch: outputs clear at once, no late done
        bus.if_addr = 32'h100; bus.if_req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        chk("midrst_ram_a", bus.ram_a, 32'd0);
        chk("midrst_if_inst", bus.if_inst, 32'd0);
        chk("midrst_mem_rdata", bus.mem_rdata, 32'd0);
        chk("midrst_if_done", {31'd0, bus.if_done}, 32'd0);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("exp_q_empty", exp_q.size(), 32'd0);
        chk("wr_q_empty", wr_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
